// File: rtl/rtr_lar_gen.sv
// rtl/rtr_lar_gen.sv - lookahead route generator: one register stage that computes the next-hop {port, class} and router address
`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_FULL
`define CONNECTIVITY_FULL 1
`endif
`ifndef ROUTING_TYPE_PHASED_DOR
`define ROUTING_TYPE_PHASED_DOR 0
`endif

module rtr_lar_gen #(
    parameter int num_resource_classes = 2,
    parameter int num_routers_per_dim  = 4,
    parameter int num_dimensions       = 2,
    parameter int num_nodes_per_router = 1,
    parameter int connectivity         = `CONNECTIVITY_LINE,
    parameter int routing_type         = `ROUTING_TYPE_PHASED_DOR,
    parameter int flit_data_width      = 64,
    localparam int dim_addr_width        = $clog2(num_routers_per_dim),
    localparam int router_addr_width     = num_dimensions * dim_addr_width,
    localparam int node_addr_width       = $clog2(num_nodes_per_router),
    localparam int dest_info_width       = num_resource_classes * router_addr_width + node_addr_width,
    localparam int num_neighbors_per_dim = (connectivity == `CONNECTIVITY_FULL) ? num_routers_per_dim - 1 : 2,
    localparam int num_ports             = num_dimensions * num_neighbors_per_dim + num_nodes_per_router,
    localparam int class_width           = $clog2(num_resource_classes),
    localparam int lar_info_width        = $clog2(num_ports) + class_width
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [router_addr_width-1:0] router_address,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_head,
    input  logic                         in_tail,
    input  logic [dest_info_width-1:0]   in_dest_info,
    input  logic [lar_info_width-1:0]    in_lar_info,
    input  logic [flit_data_width-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_head,
    output logic                         out_tail,
    output logic [flit_data_width-1:0]   out_data,
    output logic [dest_info_width-1:0]   out_dest_info,
    output logic [lar_info_width-1:0]    out_lar_info,
    output logic [router_addr_width-1:0] out_next_router_address,
    output logic                         error_pkt
);

    localparam int nrc = num_resource_classes;
    localparam int n   = num_routers_per_dim;
    localparam bit is_full = (connectivity == `CONNECTIVITY_FULL);

    if (connectivity != `CONNECTIVITY_LINE && connectivity != `CONNECTIVITY_FULL) begin : g_bad_conn
        $error("rtr_lar_gen: unsupported connectivity");
    end
    if (routing_type != `ROUTING_TYPE_PHASED_DOR) begin : g_bad_routing
        $error("rtr_lar_gen: unsupported routing_type");
    end

    typedef enum logic {IDLE, IN_PKT} state_t;
    state_t state_q, state_d;

    logic                         accept;
    logic                         framing_err;
    logic                         out_valid_q, out_valid_d;
    logic                         out_head_q, out_head_d;
    logic                         out_tail_q, out_tail_d;
    logic [flit_data_width-1:0]   out_data_q, out_data_d;
    logic [dest_info_width-1:0]   out_dest_q, out_dest_d;
    logic [lar_info_width-1:0]    out_lar_q, out_lar_d;
    logic [router_addr_width-1:0] out_addr_q, out_addr_d;
    logic                         error_q, error_d;
    logic [dest_info_width-1:0]   stored_dest_q, stored_dest_d;
    logic [lar_info_width-1:0]    stored_lar_q, stored_lar_d;
    logic [router_addr_width-1:0] stored_addr_q, stored_addr_d;

    int                           cur_port, cur_class, node, next_class, next_port;
    logic [router_addr_width-1:0] dest_cur, dest_next, next_addr;
    logic [dim_addr_width-1:0]    dest_dim, next_dim;
    logic [lar_info_width-1:0]    route_lar;

    // Reset forces in_ready high so a flit presented during reset is dropped rather than stalled.
    assign in_ready = reset | !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Lookahead route computation for a head flit; all arithmetic wraps at dim_addr_width.
    always_comb begin
        cur_port  = int'(in_lar_info) >> class_width;
        cur_class = int'(in_lar_info) & ((1 << class_width) - 1);
        node      = int'(in_dest_info >> (nrc * router_addr_width));
        dest_cur  = '0;
        for (int c = 0; c < nrc; c++) begin
            if (c == cur_class) dest_cur = in_dest_info[c*router_addr_width +: router_addr_width];
        end
        next_addr = router_address;
        for (int d = 0; d < num_dimensions; d++) begin
            if (is_full) begin
                if (cur_port >= d*(n-1) && cur_port < (d+1)*(n-1))
                    next_addr[d*dim_addr_width +: dim_addr_width] = dest_cur[d*dim_addr_width +: dim_addr_width];
            end else begin
                if (cur_port == 2*d)
                    next_addr[d*dim_addr_width +: dim_addr_width] = router_address[d*dim_addr_width +: dim_addr_width] - 1'b1;
                else if (cur_port == 2*d + 1)
                    next_addr[d*dim_addr_width +: dim_addr_width] = router_address[d*dim_addr_width +: dim_addr_width] + 1'b1;
            end
        end
        next_class = nrc - 1;
        dest_next  = in_dest_info[(nrc-1)*router_addr_width +: router_addr_width];
        for (int c = nrc - 1; c >= 0; c--) begin
            if (c >= cur_class && in_dest_info[c*router_addr_width +: router_addr_width] != next_addr) begin
                next_class = c;
                dest_next  = in_dest_info[c*router_addr_width +: router_addr_width];
            end
        end
        next_port = num_dimensions * num_neighbors_per_dim + node;
        dest_dim  = '0;
        next_dim  = '0;
        for (int d = num_dimensions - 1; d >= 0; d--) begin
            dest_dim = dest_next[d*dim_addr_width +: dim_addr_width];
            next_dim = next_addr[d*dim_addr_width +: dim_addr_width];
            if (dest_dim != next_dim) begin
                if (is_full)
                    next_port = d*(n-1) + ((int'(dest_dim) - int'(next_dim) + n) % n) - 1;
                else
                    next_port = (dest_dim < next_dim) ? 2*d : 2*d + 1;
            end
        end
        route_lar = lar_info_width'((next_port << class_width) | next_class);
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_tail)      state_d = IDLE;
            else if (in_head) state_d = IN_PKT;
        end
    end

    always_comb begin
        framing_err = accept & ((in_head & (state_q == IN_PKT)) | (!in_head & (state_q == IDLE)));
        error_d     = error_q | framing_err;
    end

    always_comb begin
        out_valid_d   = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_head_d    = out_head_q;
        out_tail_d    = out_tail_q;
        out_data_d    = out_data_q;
        out_dest_d    = out_dest_q;
        out_lar_d     = out_lar_q;
        out_addr_d    = out_addr_q;
        stored_dest_d = stored_dest_q;
        stored_lar_d  = stored_lar_q;
        stored_addr_d = stored_addr_q;
        if (accept) begin
            out_head_d = in_head;
            out_tail_d = in_tail;
            out_data_d = in_data;
            if (in_head) begin
                out_dest_d    = in_dest_info;
                out_lar_d     = route_lar;
                out_addr_d    = next_addr;
                stored_dest_d = in_dest_info;
                stored_lar_d  = route_lar;
                stored_addr_d = next_addr;
            end else begin
                out_dest_d = stored_dest_q;
                out_lar_d  = stored_lar_q;
                out_addr_d = stored_addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_head_q    <= 1'b0;
            out_tail_q    <= 1'b0;
            out_data_q    <= '0;
            out_dest_q    <= '0;
            out_lar_q     <= '0;
            out_addr_q    <= '0;
            error_q       <= 1'b0;
            stored_dest_q <= '0;
            stored_lar_q  <= '0;
            stored_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_head_q    <= out_head_d;
            out_tail_q    <= out_tail_d;
            out_data_q    <= out_data_d;
            out_dest_q    <= out_dest_d;
            out_lar_q     <= out_lar_d;
            out_addr_q    <= out_addr_d;
            error_q       <= error_d;
            stored_dest_q <= stored_dest_d;
            stored_lar_q  <= stored_lar_d;
            stored_addr_q <= stored_addr_d;
        end
    end

    assign out_valid               = out_valid_q;
    assign out_head                = out_head_q;
    assign out_tail                = out_tail_q;
    assign out_data                = out_data_q;
    assign out_dest_info           = out_dest_q;
    assign out_lar_info            = out_lar_q;
    assign out_next_router_address = out_addr_q;
    assign error_pkt               = error_q;

endmodule
